spi_master_byte: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master. Shifts one 8-bit byte out on mosi and captures one byte from miso per transaction.
- Drives sck and cs_n derived from the system clock.
- Provides the host-side end of the byte link that feeds the on-board SPI slave. Used to send PWM compare bytes and to loop back for bring-up.
- Upstream: valid/ready byte input. Downstream: single-cycle rx_valid strobe.

---
 rtl/spi_master_byte.sv | 110 +++++++++++
 tb/tb_spi_master_byte.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0, MSB-first, single-byte SPI master.
// Each transfer: SETUP, 8x(HIGH[,LOW]), HOLD, GAP; every phase lasts CLK_DIV clk cycles.
// Optional macro SPI_MASTER_BURST_EN: a byte offered in the last HOLD cycle is chained
// onto the current frame (cs_n stays low, GAP skipped).
module spi_master_byte #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              last, accept;

  // Phase ends on the cycle the half-period counter reaches zero.
  assign last   = (cnt == 8'd0);
  assign accept = tx_valid && tx_ready;
  assign mosi   = tx_sr[DATA_W-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = !rst;
        if (tx_valid && !rst) state_nxt = SETUP;
      end
      SETUP: if (last) state_nxt = HIGH;
      HIGH:  if (last) state_nxt = (bit_cnt == BW'(DATA_W-1)) ? HOLD : LOW;
      LOW:   if (last) state_nxt = HIGH;
      HOLD: begin
        if (last) begin
`ifdef SPI_MASTER_BURST_EN
          tx_ready  = !rst;
          state_nxt = (tx_valid && !rst) ? SETUP : GAP;
`else
          state_nxt = GAP;
`endif
        end
      end
      GAP:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: phase counter, shift registers and registered SPI pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 8'(CLK_DIV-1);
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // pins decoded from the next state so they change on the same edge as the state
      sck  <= (state_nxt == HIGH);
      cs_n <= (state_nxt == IDLE) || (state_nxt == GAP);
      busy <= (state_nxt != IDLE);
      cnt  <= (state == IDLE || last) ? 8'(CLK_DIV-1) : cnt - 8'd1;
      if (accept) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
      end
      // sample miso on the sck rising edge (entry into HIGH)
      if (last && (state == SETUP || state == LOW))
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      // advance mosi on sck falling edge, but hold bit 0 through HOLD
      if (state == HIGH && last) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (bit_cnt != BW'(DATA_W-1))
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
      if (state == HOLD && last) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: two instances (CLK_DIV=4 and CLK_DIV=1) with a frame
// monitor; expectations come from frame arithmetic (17*D low, 8 rises, MSB-first bits).
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sel = 1'b0;      // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
  logic       loop = 1'b1;     // 1: miso = mosi, 0: slave model drives miso
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sr = 8'h00;
  logic       miso;

  logic       tr4, rxv4, busy4, sck4, mosi4, csn4;
  logic       tr1, rxv1, busy1, sck1, mosi1, csn1;
  logic [7:0] rxd4, rxd1;
  logic       m_tr, m_rxv, m_busy, m_sck, m_mosi, m_csn;
  logic [7:0] m_rxd;

  assign m_tr   = sel ? tr1   : tr4;
  assign m_rxv  = sel ? rxv1  : rxv4;
  assign m_busy = sel ? busy1 : busy4;
  assign m_sck  = sel ? sck1  : sck4;
  assign m_mosi = sel ? mosi1 : mosi4;
  assign m_csn  = sel ? csn1  : csn4;
  assign m_rxd  = sel ? rxd1  : rxd4;
  assign miso   = loop ? m_mosi : slave_sr[7];

  spi_master_byte #(.CLK_DIV(4), .DATA_W(8)) u4 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid & ~sel), .tx_ready(tr4),
    .rx_data(rxd4), .rx_valid(rxv4), .busy(busy4), .sck(sck4), .mosi(mosi4),
    .miso(miso), .cs_n(csn4));

  spi_master_byte #(.CLK_DIV(1), .DATA_W(8)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid & sel), .tx_ready(tr1),
    .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1), .sck(sck1), .mosi(mosi1),
    .miso(miso), .cs_n(csn1));

  int n_cmp = 0;
  int n_bad = 0;

  // frame monitor state
  int   cyc = 0, low_run = 0, high_run = 0;
  logic sck_prev = 1'b0;
  int   acc_q[$], low_q[$], high_q[$], rise_q[$];
  logic mosi_q[$], rxcs_q[$];
  logic [7:0] rx_q[$];

  // Observe the selected instance away from the active edge; also run the slave model,
  // which presents its MSB at cs_n fall and shifts on each sck falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_valid && m_tr) acc_q.push_back(cyc);
    if (!m_csn) begin
      low_run++;
      if (high_run > 0) begin high_q.push_back(high_run); high_run = 0; end
    end else begin
      high_run++;
      if (low_run > 0) begin low_q.push_back(low_run); low_run = 0; end
    end
    if (m_sck && !sck_prev) begin mosi_q.push_back(m_mosi); rise_q.push_back(cyc); end
    if (m_csn) slave_sr = slave_byte;
    else if (!m_sck && sck_prev) slave_sr = {slave_sr[6:0], 1'b0};
    sck_prev = m_sck;
    if (m_rxv) begin rx_q.push_back(m_rxd); rxcs_q.push_back(m_csn); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete(); low_q.delete(); high_q.delete(); rise_q.delete();
    mosi_q.delete(); rxcs_q.delete(); rx_q.delete();
    low_run = 0; high_run = 0;
  endtask

  task automatic wait_acc(input int n, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < 400) begin @(posedge clk); k++; end
    #1;
    chk({tag, ":accept_in_time"}, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 1000) begin @(posedge clk); k++; end
    #1;
    chk({tag, ":rx_in_time"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  // One isolated transfer; the byte on tx_data is scrambled right after accept.
  task automatic xfer(input string tag, input logic [7:0] txb, input logic [7:0] exp_rx,
                      input int d);
    logic [7:0] mb;
    logic       spacing_ok;
    @(posedge clk); #1;
    clear_mon();
    tx_data = txb; tx_valid = 1'b1;
    wait_acc(1, tag);
    tx_valid = 1'b0; tx_data = ~txb;
    wait_rx(1, tag);
    repeat (2) @(posedge clk);
    #1;
    mb = 8'h00;
    foreach (mosi_q[i]) mb = {mb[6:0], mosi_q[i]};
    spacing_ok = 1'b1;
    for (int i = 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != 2*d) spacing_ok = 1'b0;
    chk({tag, ":sck_rises"},   32'(rise_q.size()), 32'd8);
    chk({tag, ":sck_period"},  32'(spacing_ok), 32'd1);
    chk({tag, ":mosi_bits"},   32'(mb), 32'(txb));
    chk({tag, ":cs_low_len"},  32'(low_q.size() > 0 ? low_q[0] : 0), 32'(17*d));
    chk({tag, ":rx_pulses"},   32'(rx_q.size()), 32'd1);
    chk({tag, ":rx_data"},     32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'(exp_rx));
    chk({tag, ":rx_on_cs_rise"}, 32'(rxcs_q.size() > 0 ? rxcs_q[0] : 1'b0), 32'd1);
  endtask

  initial begin
    logic [7:0] b, s;
    // reset values while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:sck", 32'(m_sck), 32'd0);
    chk("rst:cs_n", 32'(m_csn), 32'd1);
    chk("rst:mosi", 32'(m_mosi), 32'd0);
    chk("rst:tx_ready", 32'(m_tr), 32'd0);
    chk("rst:rx_data", 32'(m_rxd), 32'd0);
    chk("rst:rx_valid", 32'(m_rxv), 32'd0);
    chk("rst:busy", 32'(m_busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle:tx_ready", 32'(m_tr), 32'd1);

    // directed loopback and slave-driven transfers
    xfer("a5_loop", 8'hA5, 8'hA5, 4);
    loop = 1'b0; slave_byte = 8'h3C;
    xfer("ff_slave3c", 8'hFF, 8'h3C, 4);
    loop = 1'b1;

    // held tx_valid: second byte waits for IDLE; spacing 18*D+1, gap = spacing - 17*D
`ifndef SPI_MASTER_BURST_EN
    @(posedge clk); #1;
    clear_mon();
    tx_data = 8'h01; tx_valid = 1'b1;
    wait_acc(1, "pair");
    tx_data = 8'h80;
    wait_acc(2, "pair");
    tx_valid = 1'b0;
    wait_rx(2, "pair");
    repeat (2) @(posedge clk);
    #1;
    chk("pair:accept_spacing", 32'(acc_q.size() > 1 ? acc_q[1] - acc_q[0] : 0), 32'(18*4+1));
    chk("pair:cs_high_gap", 32'(high_q.size() > 1 ? high_q[1] : 0), 32'((18*4+1) - 17*4));
    chk("pair:rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h01);
    chk("pair:rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 32'h80);
`else
    @(posedge clk); #1;
    clear_mon();
    tx_data = 8'h12; tx_valid = 1'b1;
    wait_acc(1, "burst");
    tx_data = 8'h34;
    wait_acc(2, "burst");
    tx_data = 8'h56;
    wait_acc(3, "burst");
    tx_valid = 1'b0;
    wait_rx(3, "burst");
    repeat (2) @(posedge clk);
    #1;
    chk("burst:cs_runs", 32'(low_q.size()), 32'd1);
    chk("burst:cs_low_len", 32'(low_q.size() > 0 ? low_q[0] : 0), 32'(3*17*4));
    chk("burst:accept_spacing", 32'(acc_q.size() > 2 ? acc_q[2] - acc_q[1] : 0), 32'(17*4));
    chk("burst:rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h12);
    chk("burst:rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 32'h34);
    chk("burst:rx2", 32'(rx_q.size() > 2 ? rx_q[2] : 8'h00), 32'h56);
    chk("burst:rx0_cs_low", 32'(rxcs_q.size() > 0 ? rxcs_q[0] : 1'b1), 32'd0);
`endif

    // reset after the 3rd sck rising edge of 0x55
    @(posedge clk); #1;
    clear_mon();
    tx_data = 8'h55; tx_valid = 1'b1;
    wait_acc(1, "abort");
    tx_valid = 1'b0;
    begin
      int k = 0;
      while (rise_q.size() < 3 && k < 200) begin @(posedge clk); k++; end
    end
    chk("abort:third_rise_seen", 32'(rise_q.size() >= 3), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort:cs_n", 32'(m_csn), 32'd1);
    chk("abort:sck", 32'(m_sck), 32'd0);
    chk("abort:mosi", 32'(m_mosi), 32'd0);
    chk("abort:busy", 32'(m_busy), 32'd0);
    chk("abort:rx_valid", 32'(m_rxv), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort:no_rx_pulse", 32'(rx_q.size()), 32'd0);
    xfer("c3_after_abort", 8'hC3, 8'hC3, 4);

    // fastest divider
    sel = 1'b1;
    xfer("div1_81", 8'h81, 8'h81, 1);

    // randomized loopback on both dividers, then random slave data
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      b = 8'($urandom_range(0, 255));
      xfer($sformatf("rand_loop%0d", i), b, b, sel ? 1 : 4);
    end
    loop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      b = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      slave_byte = s;
      xfer($sformatf("rand_slave%0d", i), b, s, sel ? 1 : 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
